// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, registers
// the operands toward the ALU, captures the result, computes Z/N/C/V flags and
// returns result + flags over a per-requester valid/ready response channel.
module alu_arbiter #(
  parameter int DATA_W     = 8,
  parameter int OP_W       = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [2*OP_W-1:0]     req_op,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_W-1:0]     resp_c,
  output logic [7:0]            resp_flags,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_op,
  input  logic [DATA_W-1:0]     alu_c
);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(7);
  localparam logic [OP_W-1:0] OP_INC = OP_W'(10);
  localparam logic [OP_W-1:0] OP_DEC = OP_W'(11);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                rr_ptr;
  logic                gnt;
  logic                sel;
  logic                accept;
  logic                done;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [OP_W-1:0]     sel_op;
  logic                flag_z;
  logic                flag_n;
  logic                flag_c;
  logic                flag_v;

  // Grant selection among valid requesters, re-evaluated every cycle.
  always_comb begin
    sel = 1'b0;
    case (req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
      default: sel = 1'b0;
    endcase
    sel_a  = sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
    sel_b  = sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    sel_op = sel ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
  end

  // Next-state logic plus handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (|req_valid)) begin
          req_ready = sel ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        resp_valid = gnt ? 2'b10 : 2'b01;
        if (resp_ready[gnt]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flags from the latched operands and the ALU result of this cycle.
  always_comb begin
    flag_z = (alu_c == '0);
    flag_n = alu_c[DATA_W-1];
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (alu_op)
      OP_ADD: begin
        // a + b carries out exactly when a exceeds the complement of b.
        flag_c = (alu_a > ~alu_b);
        flag_v = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (alu_c[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        flag_c = (alu_a < alu_b);
        flag_v = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (alu_c[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_INC: begin
        flag_c = (alu_a == '1);
        flag_v = (alu_a == {1'b0, {(DATA_W-1){1'b1}}});
      end
      OP_DEC: begin
        flag_c = (alu_a == '0);
        flag_v = (alu_a == {1'b1, {(DATA_W-1){1'b0}}});
      end
      default: begin
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand latch, result/flag capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      gnt        <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      resp_c     <= '0;
      resp_flags <= '0;
    end else begin
      if (accept) begin
        gnt    <= sel;
        alu_a  <= sel_a;
        alu_b  <= sel_b;
        alu_op <= sel_op;
      end
      if (state == EXEC) begin
        resp_c     <= alu_c;
        resp_flags <= {4'b0000, flag_v, flag_c, flag_n, flag_z};
      end
      if (done) rr_ptr <= ~gnt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a
// transaction-level reference model; covers round-robin and fixed priority.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  resp_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_op;
  logic        sel_fp;

  logic [1:0] rv_r, rr_r, rdy_r, vld_r;
  logic [7:0] c_r, fl_r, aa_r, ab_r, ac_r;
  logic [3:0] ao_r;
  logic [1:0] rv_f, rr_f, rdy_f, vld_f;
  logic [7:0] c_f, fl_f, aa_f, ab_f, ac_f;
  logic [3:0] ao_f;

  logic [1:0] o_rdy, o_vld;
  logic [7:0] o_c, o_fl, o_a, o_b;
  logic [3:0] o_op;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic ptr;

  // Environment ALU (the arbiter only passes its result through).
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return ~a;
      4'd4:    return a;
      4'd5:    return b;
      4'd6:    return a + b;
      4'd7:    return a - b;
      4'd8:    return a << 1;
      4'd9:    return a >> 1;
      4'd10:   return a + 8'd1;
      4'd11:   return a - 8'd1;
      default: return {a[3:0], a[7:4]};
    endcase
  endfunction

  // Reference flags from integer arithmetic.
  function automatic logic [7:0] ref_flags(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op, input logic [7:0] c);
    int ua, ub, sa, sb, t;
    logic z, n, cy, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    z = (c == 8'd0); n = c[7]; cy = 1'b0; v = 1'b0;
    case (op)
      4'd6: begin cy = (ua + ub) > 255; t = sa + sb; v = (t > 127) || (t < -128); end
      4'd7: begin cy = ua < ub;         t = sa - sb; v = (t > 127) || (t < -128); end
      4'd10: begin cy = (ua == 255); v = (sa == 127);  end
      4'd11: begin cy = (ua == 0);   v = (sa == -128); end
      default: begin cy = 1'b0; v = 1'b0; end
    endcase
    return {4'b0000, v, cy, n, z};
  endfunction

  assign rv_r = sel_fp ? 2'b00 : req_valid;
  assign rr_r = sel_fp ? 2'b00 : resp_ready;
  assign rv_f = sel_fp ? req_valid : 2'b00;
  assign rr_f = sel_fp ? resp_ready : 2'b00;
  assign ac_r = alu_fn(aa_r, ab_r, ao_r);
  assign ac_f = alu_fn(aa_f, ab_f, ao_f);

  assign o_rdy = sel_fp ? rdy_f : rdy_r;
  assign o_vld = sel_fp ? vld_f : vld_r;
  assign o_c   = sel_fp ? c_f   : c_r;
  assign o_fl  = sel_fp ? fl_f  : fl_r;
  assign o_a   = sel_fp ? aa_f  : aa_r;
  assign o_b   = sel_fp ? ab_f  : ab_r;
  assign o_op  = sel_fp ? ao_f  : ao_r;

  alu_arbiter #(.DATA_W(8), .OP_W(4), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_r), .req_ready(rdy_r),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(vld_r), .resp_ready(rr_r), .resp_c(c_r), .resp_flags(fl_r),
    .alu_a(aa_r), .alu_b(ab_r), .alu_op(ao_r), .alu_c(ac_r)
  );

  alu_arbiter #(.DATA_W(8), .OP_W(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_f), .req_ready(rdy_f),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(vld_f), .resp_ready(rr_f), .resp_c(c_f), .resp_flags(fl_f),
    .alu_a(aa_f), .alu_b(ab_f), .alu_op(ao_f), .alu_c(ac_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction; inputs held valid through EXEC/RESP.
  task automatic run_op(input logic [1:0] mask,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] op0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] op1,
                        input int bp);
    logic g;
    logic [1:0] oh;
    logic [7:0] ea, eb, ec, ef;
    logic [3:0] eo;
    req_valid  = mask;
    req_a      = {a1, a0};
    req_b      = {b1, b0};
    req_op     = {op1, op0};
    resp_ready = 2'b00;
    g  = (mask == 2'b11) ? (sel_fp ? 1'b0 : ptr) : mask[1];
    oh = g ? 2'b10 : 2'b01;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    eo = g ? op1 : op0;
    ec = alu_fn(ea, eb, eo);
    ef = ref_flags(ea, eb, eo, ec);
    #1;
    check("idle_req_ready", 32'(o_rdy), 32'(oh));
    @(posedge clk); #1;
    check("exec_resp_valid", 32'(o_vld), 32'd0);
    check("exec_req_ready", 32'(o_rdy), 32'd0);
    check("alu_a", 32'(o_a), 32'(ea));
    check("alu_b", 32'(o_b), 32'(eb));
    check("alu_op", 32'(o_op), 32'(eo));
    @(posedge clk); #1;
    check("resp_valid", 32'(o_vld), 32'(oh));
    check("resp_c", 32'(o_c), 32'(ec));
    check("resp_flags", 32'(o_fl), 32'(ef));
    check("resp_req_ready", 32'(o_rdy), 32'd0);
    for (int i = 0; i < bp; i++) begin
      resp_ready = ~oh;
      @(posedge clk); #1;
      check("bp_resp_valid", 32'(o_vld), 32'(oh));
      check("bp_resp_c", 32'(o_c), 32'(ec));
      check("bp_resp_flags", 32'(o_fl), 32'(ef));
      check("bp_req_ready", 32'(o_rdy), 32'd0);
    end
    resp_ready = oh | (($urandom_range(0, 1) == 1) ? ~oh : 2'b00);
    @(posedge clk); #1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    check("release_resp_valid", 32'(o_vld), 32'd0);
    check("hold_alu_a", 32'(o_a), 32'(ea));
    if (!sel_fp) ptr = ~g;
  endtask

  function automatic logic [7:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 4'd6;
      1: return 4'd7;
      2: return 4'd10;
      3: return 4'd11;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel_fp = 1'b0; ptr = 1'b0;
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req_a = '0; req_b = '0; req_op = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(o_rdy), 32'd0);
    check("rst_resp_valid", 32'(o_vld), 32'd0);
    check("rst_resp_c", 32'(o_c), 32'd0);
    check("rst_resp_flags", 32'(o_fl), 32'd0);
    check("rst_alu_a", 32'(o_a), 32'd0);
    check("rst_alu_b", 32'(o_b), 32'd0);
    check("rst_alu_op", 32'(o_op), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_no_ready", 32'(o_rdy), 32'd0);
      check("idle_no_valid", 32'(o_vld), 32'd0);
    end

    // Directed add (carry), sub (overflow), backpressure
    run_op(2'b01, 8'hF0, 8'h20, 4'd6, 8'h00, 8'h00, 4'd0, 0);
    run_op(2'b10, 8'h00, 8'h00, 4'd0, 8'h80, 8'h01, 4'd7, 0);
    run_op(2'b01, 8'h7F, 8'h01, 4'd6, 8'h00, 8'h00, 4'd0, 4);

    // Both valid: round-robin then fixed priority
    for (int i = 0; i < 4; i++)
      run_op(2'b11, 8'h11, 8'h22, 4'd6, 8'h33, 8'h44, 4'd7, 0);
    sel_fp = 1'b1;
    for (int i = 0; i < 4; i++)
      run_op(2'b11, 8'h11, 8'h22, 4'd6, 8'h33, 8'h44, 4'd7, 0);
    sel_fp = 1'b0;

    // Increment wrap, then reset during EXEC of a second op
    run_op(2'b01, 8'hFF, 8'h00, 4'd10, 8'h00, 8'h00, 4'd0, 1);
    req_valid = 2'b01; req_a = 16'h0005; req_b = 16'h0003; req_op = 8'h06;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("midrst_resp_valid", 32'(o_vld), 32'd0);
    check("midrst_resp_c", 32'(o_c), 32'd0);
    check("midrst_alu_a", 32'(o_a), 32'd0);
    rst_n = 1'b1; ptr = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("postrst_resp_valid", 32'(o_vld), 32'd0);
      check("postrst_req_ready", 32'(o_rdy), 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) sel_fp = ~sel_fp;
      run_op(2'($urandom_range(1, 3)),
             pick_val(), pick_val(), pick_op(),
             pick_val(), pick_val(), pick_op(),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
